// File: rtl/hanzi_code_loader_pkg.sv
// Shared constants, FSM state type and byte-class helpers for the HanZi
// code loader and the keyboard-entry path that reuses gb_to_index.
package hanzi_pkg;

    // GB2312 hanzi area: high bytes A1..F7, low bytes A1..FE.
    localparam logic [7:0] GB_HI_MIN   = 8'hA1;
    localparam logic [7:0] GB_HI_MAX   = 8'hF7;
    localparam logic [7:0] GB_LO_MIN   = 8'hA1;
    localparam logic [7:0] GB_LO_MAX   = 8'hFE;
    localparam int         GB_ROW_LEN  = 94;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam int         ROM_INDEX_W = 14;

    typedef enum logic {
        S_IDLE,
        S_HAVE_HI
    } state_t;

    // True when the byte may open a character pair.
    function automatic logic is_hi_byte(input logic [7:0] b);
        return (b >= GB_HI_MIN) && (b <= GB_HI_MAX);
    endfunction

endpackage

// File: rtl/hanzi_code_loader_if.sv
// Byte stream from the UART receiver.
// Handshake: rx_valid is a one-cycle strobe per byte and rx_data is only
// meaningful while rx_valid is high. There is no ready: the receiver cannot
// be stalled, so the slave must accept a byte on every cycle, back to back.
interface hanzi_code_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/hanzi_code_loader_gb_to_index.sv
// GB2312 byte pair to linear font-ROM index: (hi-A1)*94 + (lo-A1).
// Purely combinational; the caller guarantees hi is a legal high byte.
module gb_to_index
    import hanzi_pkg::*;
(
    input  logic [7:0]             hi,
    input  logic [7:0]             lo,
    output logic [ROM_INDEX_W-1:0] index,
    output logic                   lo_ok
);

    logic [7:0]             hi_off;
    logic [7:0]             lo_off;
    logic [ROM_INDEX_W-1:0] hi_ext;
    logic [ROM_INDEX_W-1:0] row_base;

    // Row offset times 94 as shift-add (64+16+8+4+2); max 8084 fits 14 bits.
    always_comb begin
        hi_off   = hi - GB_HI_MIN;
        lo_off   = lo - GB_LO_MIN;
        hi_ext   = {6'b0, hi_off};
        row_base = (hi_ext << 6) + (hi_ext << 4) + (hi_ext << 3)
                 + (hi_ext << 2) + (hi_ext << 1);
        index    = row_base + {6'b0, lo_off};
        lo_ok    = (lo >= GB_LO_MIN) && (lo <= GB_LO_MAX);
    end

endmodule

// File: rtl/hanzi_code_loader.sv
// Pairs GB2312 bytes from the UART into font-ROM indices and packs them into
// the flat zb_code bus read by the VGA display stage. Handles clear (port or
// form feed), malformed bytes and a half-character timeout.
module hanzi_code_loader
    import hanzi_pkg::*;
#(
    parameter int NUM_CHARS      = 12,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                    clk,
    input  logic                    reset,
    hanzi_code_loader_if.slave      rx,
    input  logic                    clear,
    output logic [16*NUM_CHARS-1:0] zb_code,
    output logic [3:0]              char_count,
    output logic                    frame_done,
    output logic                    err,
    output logic                    overflow,
    output state_t                  dbg_state
);

    localparam int               CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       NUM_CHARS_C = 4'(NUM_CHARS);

    state_t                  state_q;
    logic [7:0]              hi_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [16*NUM_CHARS-1:0] zb_q;
    logic [3:0]              count_q;
    logic                    frame_done_q;
    logic                    err_q;
    logic                    overflow_q;

    logic [ROM_INDEX_W-1:0]  index_d;
    logic                    lo_ok;

    gb_to_index u_gb_to_index (
        .hi    (hi_q),
        .lo    (rx.rx_data),
        .index (index_d),
        .lo_ok (lo_ok)
    );

    // Pair FSM, slot buffer and event pulses; clear outranks any byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hi_q         <= '0;
            cnt_q        <= '0;
            zb_q         <= '0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
            if (clear) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                zb_q    <= '0;
                count_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rx.rx_valid) begin
                            if (rx.rx_data == ASCII_FF) begin
                                zb_q    <= '0;
                                count_q <= '0;
                            end else if (is_hi_byte(rx.rx_data)) begin
                                hi_q    <= rx.rx_data;
                                cnt_q   <= '0;
                                state_q <= S_HAVE_HI;
                            end else if (rx.rx_data[7]) begin
                                // 80..A0 and F8..FF; plain ASCII is ignored.
                                err_q <= 1'b1;
                            end
                        end
                    end
                    S_HAVE_HI: begin
                        if (rx.rx_valid) begin
                            // A bad low byte ends the pair; it never restarts one.
                            state_q <= S_IDLE;
                            if (!lo_ok) begin
                                err_q <= 1'b1;
                            end else if (count_q < NUM_CHARS_C) begin
                                zb_q[{count_q, 4'b0} +: 16] <= {2'b00, index_d};
                                count_q <= count_q + 4'd1;
                                frame_done_q <= (count_q == NUM_CHARS_C - 4'd1);
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end else if (cnt_q == TO_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign zb_code    = zb_q;
    assign char_count = count_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;
    assign overflow   = overflow_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_hanzi_code_loader.sv
// Directed bench for hanzi_code_loader with hand-computed slot values.
module tb_hanzi_code_loader;
    import hanzi_pkg::*;

    localparam int NC = 12;
    localparam int TO = 16;

    logic           clk;
    logic           reset;
    logic           clear;
    logic [16*NC-1:0] zb_code;
    logic [3:0]     char_count;
    logic           frame_done;
    logic           err;
    logic           overflow;
    state_t         dbg_state;

    int n_cmp = 0;
    int n_mis = 0;
    int n_fd  = 0;
    int n_err = 0;
    int n_ov  = 0;

    hanzi_code_loader_if rx_if ();

    hanzi_code_loader #(.NUM_CHARS(NC), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_if),
        .clear      (clear),
        .zb_code    (zb_code),
        .char_count (char_count),
        .frame_done (frame_done),
        .err        (err),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (frame_done) n_fd++;
        if (err)        n_err++;
        if (overflow)   n_ov++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] slot(input int k);
        return zb_code[16*k +: 16];
    endfunction

    // driver tasks: called and returning at a falling edge
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] hi, input logic [7:0] lo);
        send_byte(hi);
        send_byte(lo);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        clear = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_zb_any", 32'(|zb_code), 32'd0);
        check("rst_count", 32'(char_count), 32'd0);
        check("rst_pulses", {29'd0, frame_done, err, overflow}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // single character B0 A1 -> 1410
        n_err = 0;
        send_pair(8'hB0, 8'hA1);
        check("b0a1_slot0", 32'(slot(0)), 32'h0582);
        check("b0a1_count", 32'(char_count), 32'd1);
        check("b0a1_noerr", n_err, 0);
        do_clear();

        // range corners, back to back
        send_pair(8'hA1, 8'hA1);
        send_pair(8'hF7, 8'hFE);
        check("corner_slot0", 32'(slot(0)), 32'h0000);
        check("corner_slot1", 32'(slot(1)), 32'h1FF1);
        check("corner_count", 32'(char_count), 32'd2);
        do_clear();

        // fill all slots, then overflow; pair (A1+k, A1+k) -> 95*k
        n_fd = 0; n_ov = 0;
        for (int k = 0; k < NC; k++) begin
            send_pair(8'(8'hA1 + k), 8'(8'hA1 + k));
            if (k == NC - 1) check("fill_fd_pulse", 32'(frame_done), 32'd1);
        end
        check("fill_count", 32'(char_count), 32'd12);
        send_byte(8'hA1);
        check("fd_one_cycle", 32'(frame_done), 32'd0);
        send_byte(8'hA2);
        check("ov_pulse", 32'(overflow), 32'd1);
        @(negedge clk);
        check("ov_one_cycle", 32'(overflow), 32'd0);
        check("ov_count", n_ov, 1);
        check("fd_count", n_fd, 1);
        check("full_count", 32'(char_count), 32'd12);
        for (int k = 0; k < NC; k++) check($sformatf("full_slot%0d", k), 32'(slot(k)), 32'(95 * k));
        do_clear();

        // bad low byte, then a good pair
        n_err = 0;
        send_pair(8'hB0, 8'h41);
        check("badlo_err", 32'(err), 32'd1);
        check("badlo_count", 32'(char_count), 32'd0);
        check("badlo_state", 32'(dbg_state), 32'(S_IDLE));
        send_pair(8'hC4, 8'hE3);
        check("c4e3_slot0", 32'(slot(0)), 32'h0D1C);
        check("c4e3_count", 32'(char_count), 32'd1);
        check("badlo_errs", n_err, 1);

        // bad high byte in IDLE, ASCII ignored
        n_err = 0;
        send_byte(8'hF8);
        check("badhi_err", 32'(err), 32'd1);
        send_byte(8'h41);
        check("ascii_state", 32'(dbg_state), 32'(S_IDLE));
        check("badhi_errs", n_err, 1);

        // timeout: err exactly TO cycles after the high byte edge
        n_err = 0;
        send_byte(8'hB0);
        n = 0;
        while (!err && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_delay", n, TO);
        check("to_state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clk);
        check("to_errs", n_err, 1);
        send_byte(8'hA1);
        check("to_after_hi_state", 32'(dbg_state), 32'(S_HAVE_HI));
        check("to_after_hi_count", 32'(char_count), 32'd1);
        do_clear();

        // low byte on the expiry cycle wins over the timeout
        n_err = 0;
        send_byte(8'hB0);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'hA1);
        check("expiry_slot0", 32'(slot(0)), 32'h0582);
        check("expiry_count", 32'(char_count), 32'd1);
        @(negedge clk);
        check("expiry_noerr", n_err, 0);

        // clear with a simultaneous byte
        do_clear();
        n_err = 0; n_fd = 0;
        send_pair(8'hB0, 8'hA1);
        send_pair(8'hC4, 8'hE3);
        send_pair(8'hA1, 8'hA2);
        check("three_count", 32'(char_count), 32'd3);
        clear = 1'b1;
        rx_if.rx_data  = 8'hB0;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        rx_if.rx_valid = 1'b0;
        check("clr_zb_any", 32'(|zb_code), 32'd0);
        check("clr_count", 32'(char_count), 32'd0);
        check("clr_state", 32'(dbg_state), 32'(S_IDLE));

        // form feed mid-buffer
        send_pair(8'hB0, 8'hA1);
        send_pair(8'hC4, 8'hE3);
        send_byte(8'h0C);
        check("ff_zb_any", 32'(|zb_code), 32'd0);
        check("ff_count", 32'(char_count), 32'd0);
        @(negedge clk);
        check("clr_ff_noerr", n_err, 0);
        check("clr_ff_nofd", n_fd, 0);

        // async reset while holding a high byte
        send_pair(8'hB0, 8'hA1);
        send_byte(8'hB0);
        check("prerst_state", 32'(dbg_state), 32'(S_HAVE_HI));
        #2 reset = 1'b1;
        #1;
        check("arst_zb_any", 32'(|zb_code), 32'd0);
        check("arst_count", 32'(char_count), 32'd0);
        check("arst_state", 32'(dbg_state), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_byte(8'hA1);
        check("postrst_state", 32'(dbg_state), 32'(S_HAVE_HI));
        check("postrst_count", 32'(char_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
